// File: rtl/tone_period_meter.sv
// Measures the edge-to-edge interval of an asynchronous square wave in clk cycles
// and reports lock/loss of the tone.
module tone_period_meter #(
    parameter int unsigned CLOCK_FREQUENCY = 125_000_000,
    parameter logic [23:0] TIMEOUT_CYCLES  = 24'hFF_FFFF,
    parameter logic [3:0]  LOCK_COUNT      = 4'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        square_wave_in,
    output logic [23:0] half_period,
    output logic        period_valid,
    output logic        tone_present,
    output logic        edge_rising
);

    generate
        if (CLOCK_FREQUENCY == 0 || TIMEOUT_CYCLES < 24'd2 || LOCK_COUNT == 4'd0) begin : g_bad_cfg
            $error("tone_period_meter: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        MEASURING = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [23:0] counter, counter_nx;
    logic [3:0]  lock, lock_nx;
    logic [23:0] hp_nx;
    logic        pv_nx, er_nx;
    logic        sync1, sync2, prev;
    logic        edge_det;

    assign edge_det     = sync2 ^ prev;
    assign tone_present = (lock == LOCK_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            prev         <= 1'b0;
            state        <= IDLE;
            counter      <= '0;
            lock         <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            edge_rising  <= 1'b0;
        end else begin
            sync1        <= square_wave_in;
            sync2        <= sync1;
            prev         <= sync2;
            state        <= state_nx;
            counter      <= counter_nx;
            lock         <= lock_nx;
            half_period  <= hp_nx;
            period_valid <= pv_nx;
            edge_rising  <= er_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        lock_nx    = lock;
        hp_nx      = half_period;
        pv_nx      = 1'b0;
        er_nx      = 1'b0;
        if (!enable) begin
            state_nx   = IDLE;
            counter_nx = '0;
            lock_nx    = '0;
        end else begin
            er_nx = edge_det && sync2 && (state == ARMED || state == MEASURING);
            case (state)
                IDLE: begin
                    counter_nx = '0;
                    state_nx   = ARMED;
                end
                ARMED: begin
                    if (edge_det) begin
                        counter_nx = 24'd1;
                        state_nx   = MEASURING;
                    end
                end
                MEASURING: begin
                    // An edge on the timeout cycle still counts as a capture.
                    if (edge_det) begin
                        hp_nx      = counter;
                        pv_nx      = 1'b1;
                        counter_nx = 24'd1;
                        if (lock != LOCK_COUNT) lock_nx = lock + 4'd1;
                    end else if (counter == TIMEOUT_CYCLES) begin
                        state_nx   = ARMED;
                        counter_nx = '0;
                        lock_nx    = '0;
                    end else if (!(&counter)) begin
                        counter_nx = counter + 24'd1;
                    end
                end
                default: begin
                    state_nx   = IDLE;
                    counter_nx = '0;
                    lock_nx    = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Scoreboard bench: expected captures are queued as each toggle is scheduled and
// matched against period_valid pulses.
module tb_tone_period_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        square_wave_in;
    logic [23:0] half_period;
    logic        period_valid;
    logic        tone_present;
    logic        edge_rising;

    typedef struct packed {
        logic [23:0] hp;
        logic        tp;
        logic        er;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tone_period_meter #(
        .CLOCK_FREQUENCY(125_000_000),
        .TIMEOUT_CYCLES (24'd1000),
        .LOCK_COUNT     (4'd2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .square_wave_in(square_wave_in),
        .half_period   (half_period),
        .period_valid  (period_valid),
        .tone_present  (tone_present),
        .edge_rising   (edge_rising)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Wait n cycles then toggle; optionally queue the capture that toggle should cause.
    task automatic half(input int n, input bit push, input bit tp);
        if (push) q.push_back({24'(n), tp, ~square_wave_in});
        repeat (n) @(negedge clk);
        square_wave_in = ~square_wave_in;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (period_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_pv", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("half_period", 32'(half_period), 32'(e.hp));
                chk("tone_present", 32'(tone_present), 32'(e.tp));
                chk("edge_rising", 32'(edge_rising), 32'(e.er));
            end
        end
    end

    initial begin
        int pulses;
        reset = 1'b1;
        enable = 1'b1;
        square_wave_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hp", 32'(half_period), 32'd0);
        chk("rst_pv", 32'(period_valid), 32'd0);
        chk("rst_tp", 32'(tone_present), 32'd0);
        chk("rst_er", 32'(edge_rising), 32'd0);
        reset = 1'b0;

        // Steady 100-cycle tone: first edge arms, lock on the 2nd capture
        half(100, 0, 0);
        for (int i = 1; i <= 5; i++) half(100, 1, i >= 2);

        // Latency: rising edge while measuring, pulses exactly 3 edges later
        half(100, 1, 1);
        @(negedge clk); chk("lat1_pv", 32'(period_valid), 32'd0); chk("lat1_er", 32'(edge_rising), 32'd0);
        @(negedge clk); chk("lat2_pv", 32'(period_valid), 32'd0); chk("lat2_er", 32'(edge_rising), 32'd0);
        @(negedge clk); chk("lat3_pv", 32'(period_valid), 32'd1); chk("lat3_er", 32'(edge_rising), 32'd1);
        @(negedge clk); chk("lat4_pv", 32'(period_valid), 32'd0); chk("lat4_er", 32'(edge_rising), 32'd0);

        // Timeout after 1000 edge-free cycles
        repeat (998) @(negedge clk);
        chk("pre_timeout_tp", 32'(tone_present), 32'd1);
        @(negedge clk);
        chk("timeout_tp", 32'(tone_present), 32'd0);
        chk("timeout_hp", 32'(half_period), 32'd100);
        half(50, 0, 0);
        half(100, 1, 0);

        // Edge exactly at the timeout count is a capture; one cycle later is not
        half(1000, 1, 1);
        half(1001, 0, 0);
        half(100, 1, 0);
        half(100, 1, 1);
        half(100, 1, 1);

        // Reset mid half-period
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_hp", 32'(half_period), 32'd0);
        chk("mid_rst_pv", 32'(period_valid), 32'd0);
        chk("mid_rst_tp", 32'(tone_present), 32'd0);
        chk("mid_rst_er", 32'(edge_rising), 32'd0);
        reset = 1'b0;
        half(59, 0, 0);
        half(100, 1, 0);
        half(100, 1, 1);

        // Enable dropped while locked
        repeat (30) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_tp", 32'(tone_present), 32'd0);
        chk("dis_hp", 32'(half_period), 32'd100);
        pulses = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (i == 70 || i == 170) square_wave_in = ~square_wave_in;
            if (period_valid || edge_rising) pulses++;
        end
        chk("dis_pulses", 32'(pulses), 32'd0);
        chk("dis_hold_hp", 32'(half_period), 32'd100);
        enable = 1'b1;
        half(100, 0, 0);
        half(100, 1, 0);

        repeat (10) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
